rush3d_csr_slave: RTL and testbench

Host-facing Avalon-MM slave that owns the 64-bit control/status word consumed by rush3d_controller. It accepts clear-backs from the controller, background colour and vertex words from the host, and exposes pipeline status. It also raises a swap-complete interrupt. It sits between the HPS lightweight bridge and rush3d_controller / vertex FIFO.

---
 rtl/rush3d_pkg.sv | 26 ++
 rtl/rush3d_csr_slave.sv | 116 +++++++++++
 tb/tb_rush3d_csr_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rush3d_pkg.sv
// Shared definitions for the rush3d CSR slave and controller:
// register map, control-word bit positions and write-state encodings.
package rush3d_pkg;

   localparam int unsigned REG_CS_LO       = 0;
   localparam int unsigned REG_CS_HI       = 1;
   localparam int unsigned REG_BG_COLOUR   = 2;
   localparam int unsigned REG_VERTEX_DATA = 3;
   localparam int unsigned REG_STATUS      = 4;
   localparam int unsigned REG_IRQ         = 5;

   localparam int unsigned CS_VALID_VERTICES = 0;
   localparam int unsigned CS_BACKGROUND     = 4;
   localparam int unsigned CS_SWAP_BUFFER    = 8;

   // Command bits: set by the host, cleared back by the controller
   localparam logic [63:0] CMD_MASK = 64'h0000_0000_0000_0111;

   typedef enum logic [3:0] {
      FB_WAIT       = 4'd0,
      FB_WRITE      = 4'd1,
      FB_PURGE      = 4'd2,
      FB_BACKGROUND = 4'd3
   } fb_write_state_e;

endpackage

// File: rtl/rush3d_csr_slave.sv
// Avalon-MM CSR slave owning the 64-bit control/status word, background
// colour, vertex FIFO push path, pipeline status and swap-complete IRQ.
module rush3d_csr_slave
   import rush3d_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 3,
   parameter int unsigned VERTEX_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   avs_address,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   input  logic                    avs_read,
   output logic [31:0]             avs_readdata,
   output logic                    avs_readdatavalid,
   output logic                    avs_waitrequest,
   output logic [63:0]             control_status,
   input  logic                    ctrl_load,
   input  logic [63:0]             ctrl_load_data,
   output logic [31:0]             background_colour,
   output logic                    vertex_wr,
   output logic [VERTEX_WIDTH-1:0] vertex_data,
   input  logic                    vertex_fifo_full,
   input  logic                    vertex_fifo_empty,
   input  logic                    pixel_fifo_empty,
   input  logic                    current_buffer,
   input  logic [3:0]              framebuffer_write_state,
   input  logic [3:0]              rasteriser_state,
   output logic                    irq
);

   localparam logic [ADDR_WIDTH-1:0] A_CS_LO  = ADDR_WIDTH'(REG_CS_LO);
   localparam logic [ADDR_WIDTH-1:0] A_CS_HI  = ADDR_WIDTH'(REG_CS_HI);
   localparam logic [ADDR_WIDTH-1:0] A_BG     = ADDR_WIDTH'(REG_BG_COLOUR);
   localparam logic [ADDR_WIDTH-1:0] A_VERTEX = ADDR_WIDTH'(REG_VERTEX_DATA);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(REG_STATUS);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ    = ADDR_WIDTH'(REG_IRQ);

   logic [63:0] cs_q;
   logic [63:0] cs_next;
   logic [63:0] cmd_kept;
   logic [63:0] host_w1s;
   logic [31:0] bg_q;
   logic [31:0] rd_mux;
   logic        irq_pending;
   logic        irq_enable;
   logic        pending_next;
   logic        swap_fall;
   logic        wr_acc;
   logic        wr_cs_lo;
   logic        wr_cs_hi;
   logic        wr_bg;
   logic        wr_vtx;
   logic        wr_irq;

   assign avs_waitrequest   = avs_write & vertex_fifo_full & (avs_address == A_VERTEX);
   assign control_status    = cs_q;
   assign background_colour = bg_q;
   assign irq               = irq_pending & irq_enable;

   always_comb begin
      wr_acc   = avs_write & ~avs_waitrequest;
      wr_cs_lo = wr_acc & (avs_address == A_CS_LO);
      wr_cs_hi = wr_acc & (avs_address == A_CS_HI);
      wr_bg    = wr_acc & (avs_address == A_BG);
      wr_vtx   = wr_acc & (avs_address == A_VERTEX);
      wr_irq   = wr_acc & (avs_address == A_IRQ);

      // Controller may only clear command bits; a host set in the same cycle still lands
      host_w1s = wr_cs_lo ? ({32'h0, avs_writedata} & CMD_MASK) : '0;
      cmd_kept = ctrl_load ? (cs_q & ctrl_load_data & CMD_MASK) : (cs_q & CMD_MASK);

      cs_next = cs_q;
      if (wr_cs_lo) cs_next[31:0]  = avs_writedata;
      if (wr_cs_hi) cs_next[63:32] = avs_writedata;
      cs_next = (cs_next & ~CMD_MASK) | cmd_kept | host_w1s;

      swap_fall    = cs_q[CS_SWAP_BUFFER] & ~cs_next[CS_SWAP_BUFFER];
      pending_next = (irq_pending & ~(wr_irq & avs_writedata[0])) | swap_fall;

      case (avs_address)
         A_CS_LO:  rd_mux = cs_q[31:0];
         A_CS_HI:  rd_mux = cs_q[63:32];
         A_BG:     rd_mux = bg_q;
         A_STATUS: rd_mux = {16'h0, framebuffer_write_state, rasteriser_state, 4'h0,
                             current_buffer, pixel_fifo_empty, vertex_fifo_empty,
                             vertex_fifo_full};
         A_IRQ:    rd_mux = {30'h0, irq_enable, irq_pending};
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cs_q              <= '0;
         bg_q              <= '0;
         irq_pending       <= 1'b0;
         irq_enable        <= 1'b0;
         avs_readdatavalid <= 1'b0;
         avs_readdata      <= '0;
         vertex_wr         <= 1'b0;
         vertex_data       <= '0;
      end else begin
         cs_q              <= cs_next;
         irq_pending       <= pending_next;
         avs_readdatavalid <= avs_read;
         vertex_wr         <= wr_vtx;
         if (wr_bg)    bg_q         <= avs_writedata;
         if (wr_irq)   irq_enable   <= avs_writedata[1];
         if (avs_read) avs_readdata <= rd_mux;
         if (wr_vtx)   vertex_data  <= VERTEX_WIDTH'(avs_writedata);
      end
   end

endmodule

// File: tb/tb_rush3d_csr_slave.sv
// Self-checking bench for rush3d_csr_slave: directed register-map scenarios
// followed by randomized traffic against a behavioural register model.
module tb_rush3d_csr_slave;
   import rush3d_pkg::*;

   localparam int unsigned AW = 3;
   localparam int unsigned VW = 32;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] avs_address = '0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic          avs_read = 1'b0;
   logic [31:0]   avs_readdata;
   logic          avs_readdatavalid;
   logic          avs_waitrequest;
   logic [63:0]   control_status;
   logic          ctrl_load = 1'b0;
   logic [63:0]   ctrl_load_data = '0;
   logic [31:0]   background_colour;
   logic          vertex_wr;
   logic [VW-1:0] vertex_data;
   logic          vertex_fifo_full = 1'b0;
   logic          vertex_fifo_empty = 1'b1;
   logic          pixel_fifo_empty = 1'b1;
   logic          current_buffer = 1'b0;
   logic [3:0]    framebuffer_write_state = '0;
   logic [3:0]    rasteriser_state = '0;
   logic          irq;

   always #5 clock = ~clock;

   rush3d_csr_slave #(.ADDR_WIDTH(AW), .VERTEX_WIDTH(VW)) dut (
      .clock(clock), .reset(reset),
      .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_read(avs_read), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
      .control_status(control_status), .ctrl_load(ctrl_load), .ctrl_load_data(ctrl_load_data),
      .background_colour(background_colour), .vertex_wr(vertex_wr), .vertex_data(vertex_data),
      .vertex_fifo_full(vertex_fifo_full), .vertex_fifo_empty(vertex_fifo_empty),
      .pixel_fifo_empty(pixel_fifo_empty), .current_buffer(current_buffer),
      .framebuffer_write_state(framebuffer_write_state), .rasteriser_state(rasteriser_state),
      .irq(irq)
   );

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;

   // Reference model state
   logic [63:0] m_cs;
   logic [31:0] m_bg;
   bit          m_pend;
   bit          m_en;
   int unsigned cmd_bits[3] = '{CS_VALID_VERTICES, CS_BACKGROUND, CS_SWAP_BUFFER};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int unsigned a);
      case (a)
         0: return m_cs[31:0];
         1: return m_cs[63:32];
         2: return m_bg;
         4: return {16'h0, framebuffer_write_state, rasteriser_state, 4'h0,
                    current_buffer, pixel_fifo_empty, vertex_fifo_empty, vertex_fifo_full};
         5: return {30'h0, m_en, m_pend};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_cs = '0; m_bg = '0; m_pend = 0; m_en = 0;
   endtask

   task automatic drive(input bit wr, input bit rd, input int unsigned addr,
                        input logic [31:0] wdata, input bit ld, input logic [63:0] ldata,
                        input bit full);
      avs_write = wr; avs_read = rd; avs_address = AW'(addr); avs_writedata = wdata;
      ctrl_load = ld; ctrl_load_data = ldata; vertex_fifo_full = full;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 0, 64'h0, 0);
   endtask

   // One clock: check stall, predict next state from the current inputs, clock, compare
   task automatic cycle();
      int unsigned a;
      bit acc, n_rv, n_vwr, b;
      logic [31:0] n_rd, n_vd;
      logic [63:0] ncs;
      #1;
      a = int'(avs_address);
      check("waitrequest", avs_waitrequest, avs_write && a == 3 && vertex_fifo_full);
      acc   = avs_write && !(a == 3 && vertex_fifo_full);
      n_rv  = avs_read;
      n_rd  = model_read(a);
      n_vwr = acc && a == 3;
      n_vd  = avs_writedata;
      ncs   = m_cs;
      if (acc && a == 0) ncs[31:0]  = avs_writedata;
      if (acc && a == 1) ncs[63:32] = avs_writedata;
      foreach (cmd_bits[i]) begin
         b = m_cs[cmd_bits[i]];
         if (ctrl_load && !ctrl_load_data[cmd_bits[i]]) b = 0;
         if (acc && a == 0 && avs_writedata[cmd_bits[i]]) b = 1;
         ncs[cmd_bits[i]] = b;
      end
      if (acc && a == 2) m_bg = avs_writedata;
      if (acc && a == 5) begin
         m_en = avs_writedata[1];
         if (avs_writedata[0]) m_pend = 0;
      end
      if (m_cs[8] && !ncs[8]) m_pend = 1;
      m_cs = ncs;
      @(posedge clock);
      #1;
      check("control_status", control_status, m_cs);
      check("background_colour", background_colour, {32'h0, m_bg});
      check("irq", irq, m_pend && m_en);
      check("readdatavalid", avs_readdatavalid, n_rv);
      if (n_rv) check("readdata", avs_readdata, {32'h0, n_rd});
      check("vertex_wr", vertex_wr, n_vwr);
      if (n_vwr) check("vertex_data", vertex_data, {32'h0, n_vd});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs"}, control_status, 64'h0);
      check({tag, "_bg"}, background_colour, 64'h0);
      check({tag, "_irq"}, irq, 0);
      check({tag, "_rvalid"}, avs_readdatavalid, 0);
      check({tag, "_rdata"}, avs_readdata, 64'h0);
      check({tag, "_vwr"}, vertex_wr, 0);
      check({tag, "_vdata"}, vertex_data, 64'h0);
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #2 check_reset_outputs("reset");
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      idle(); cycle();

      // Command bit set, then held controller clear-back
      drive(1, 0, 0, 32'h10, 0, 64'h0, 0); cycle();
      check("cs_set_bg", control_status, 64'h10);
      repeat (3) begin drive(0, 0, 0, 32'h0, 1, 64'h0, 0); cycle(); end
      check("cs_cleared", control_status, 64'h0);

      // Host set in the same cycle as a clear-back
      drive(1, 0, 0, 32'h01, 0, 64'h0, 0); cycle();
      drive(1, 0, 0, 32'h100, 1, 64'h0, 0); cycle();
      check("cs_set_wins", control_status, 64'h100);
      drive(0, 0, 0, 32'h0, 1, 64'h0, 0); cycle();

      // CS_HI / CS_LO readback
      drive(1, 0, 1, 32'hDEADBEEF, 0, 64'h0, 0); cycle();
      drive(1, 0, 0, 32'h12345600, 0, 64'h0, 0); cycle();
      drive(0, 1, 1, 32'h0, 0, 64'h0, 0); cycle();
      check("rd_cs_hi", avs_readdata, 64'hDEADBEEF);
      drive(0, 1, 0, 32'h0, 0, 64'h0, 0); cycle();
      check("rd_cs_lo", avs_readdata, 64'h12345600);
      idle(); cycle();

      // Vertex write stalled by a full FIFO
      repeat (3) begin drive(1, 0, 3, 32'hA5A5, 0, 64'h0, 1); cycle(); end
      drive(1, 0, 3, 32'hA5A5, 0, 64'h0, 0); cycle();
      check("vtx_push", vertex_wr, 1);
      check("vtx_word", vertex_data, 64'hA5A5);
      idle(); cycle();

      // Swap-complete interrupt
      drive(1, 0, 5, 32'h3, 0, 64'h0, 0); cycle();
      drive(1, 0, 0, 32'h100, 0, 64'h0, 0); cycle();
      drive(0, 0, 0, 32'h0, 1, 64'h0, 0); cycle();
      check("irq_raised", irq, 1);
      drive(0, 1, 5, 32'h0, 0, 64'h0, 0); cycle();
      check("rd_irq", avs_readdata, 64'h3);
      drive(1, 0, 5, 32'h3, 0, 64'h0, 0); cycle();
      check("irq_cleared", irq, 0);
      drive(0, 1, 5, 32'h0, 0, 64'h0, 0); cycle();
      check("rd_irq_en", avs_readdata, 64'h2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit wr, rd;
         int unsigned op = $urandom_range(0, 9);
         wr = (op < 5);
         rd = (op >= 5 && op < 8);
         drive(wr, rd, $urandom_range(0, 7), $urandom, ($urandom_range(0, 3) == 0),
               {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
         vertex_fifo_empty       = 1'($urandom);
         pixel_fifo_empty        = 1'($urandom);
         current_buffer          = 1'($urandom);
         framebuffer_write_state = 4'($urandom);
         rasteriser_state        = 4'($urandom);
         cycle();
      end

      // Reset with a read response outstanding and a vertex write stalled
      drive(0, 1, 2, 32'h0, 0, 64'h0, 0);
      @(posedge clock); #1;
      drive(1, 0, 3, 32'h5A5A, 0, 64'h0, 1);
      reset = 1'b1;
      #2 check_reset_outputs("mid_reset");
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      idle();
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
